// File: rtl/instr_mem_pipelined_if.sv
// instr_mem_pipelined_if: fetch, hazard-control and program-load signals of the instruction memory
interface instr_mem_pipelined_if #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  stall;
   logic                  flush;
   logic                  ready;
   logic [WORD_WIDTH-1:0] instruction;
   logic                  inst_valid;
   logic                  addr_err;
   logic                  prog_we;
   logic [ADDR_WIDTH-1:0] prog_addr;
   logic [WORD_WIDTH-1:0] prog_data;
   modport master (
      output req, addr, stall, flush, prog_we, prog_addr, prog_data,
      input  ready, instruction, inst_valid, addr_err
   );
   modport slave (
      input  req, addr, stall, flush, prog_we, prog_addr, prog_data,
      output ready, instruction, inst_valid, addr_err
   );
endinterface

// File: rtl/instr_mem_pipelined.sv
// instr_mem_pipelined: programmable instruction RAM with a stallable, flushable read pipeline
module instr_mem_pipelined #(
   parameter int                    WORD_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 64,
   parameter int                    LATENCY    = 1,
   parameter logic [WORD_WIDTH-1:0] NOP_WORD   = '0
) (
   input logic                  clk,
   input logic                  rst,
   instr_mem_pipelined_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [LATENCY-1:0]    valid_q, valid_d, err_q, err_d;
   logic [WORD_WIDTH-1:0] data_q [LATENCY];
   logic [WORD_WIDTH-1:0] data_d [LATENCY];
   logic [IW-1:0]         rd_idx, wr_idx;
   logic                  rd_ok, wr_ok, wr_en, accept;
   logic [WORD_WIDTH-1:0] rd_word;
   logic                  unused;
   assign unused = ^bus.prog_addr[1:0];
   assign bus.ready       = ~bus.stall & ~rst;
   assign bus.instruction = data_q[LATENCY-1];
   assign bus.inst_valid  = valid_q[LATENCY-1];
   assign bus.addr_err    = valid_q[LATENCY-1] & err_q[LATENCY-1];
   always_comb begin
      rd_idx  = bus.addr[IW+1:2];
      wr_idx  = bus.prog_addr[IW+1:2];
      rd_ok   = (bus.addr[ADDR_WIDTH-1:IW+2] == '0) && (bus.addr[1:0] == 2'b00);
      wr_ok   = bus.prog_addr[ADDR_WIDTH-1:IW+2] == '0;
      wr_en   = bus.prog_we & ~rst & wr_ok;
      accept  = bus.req & bus.ready & ~bus.flush;
      // write-first: a same-cycle program write to the fetched word wins
      rd_word = !rd_ok ? NOP_WORD : (wr_en && wr_idx == rd_idx) ? bus.prog_data : mem[rd_idx];
      valid_d = valid_q;
      err_d   = err_q;
      data_d  = data_q;
      if (bus.flush) begin
         valid_d = '0;
      end else if (!bus.stall) begin
         valid_d[0] = accept;
         if (accept) begin
            data_d[0] = rd_word;
            err_d[0]  = ~rd_ok;
         end
         // bubbles carry no data, so the output word holds until the next valid fetch
         for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
               data_d[i] = data_q[i-1];
               err_d[i]  = err_q[i-1];
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         err_q   <= '0;
         data_q  <= '{default: '0};
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= bus.prog_data;
   end
endmodule

// File: tb/tb_instr_mem_pipelined.sv
// tb_instr_mem_pipelined: scoreboard bench running LATENCY 1, 2 and 3 instances on shared stimulus
module tb_instr_mem_pipelined;
   typedef struct packed {
      logic [31:0] d;
      logic        e;
      int          k;
      int          s;
   } ent_t;
   logic        clk = 0;
   logic        rst, req, stall, flush, prog_we;
   logic [31:0] addr, prog_addr, prog_data;
   logic [31:0] model [64];
   ent_t        sb [3][$];
   int          cyc = 0;
   int          stall_n = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) stall_n <= stall_n + (stall ? 1 : 0);
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   for (genvar g = 0; g < 3; g++) begin : u
      instr_mem_pipelined_if #(.WORD_WIDTH(32), .ADDR_WIDTH(32)) b ();
      instr_mem_pipelined #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .LATENCY(g + 1),
                            .NOP_WORD(32'h0)) dut (.clk(clk), .rst(rst), .bus(b));
      assign b.req       = req;
      assign b.addr      = addr;
      assign b.stall     = stall;
      assign b.flush     = flush;
      assign b.prog_we   = prog_we;
      assign b.prog_addr = prog_addr;
      assign b.prog_data = prog_data;
      bit          rst_d = 0, stall_d = 0, prev_v = 0;
      logic [31:0] prev_ins = 0;
      ent_t        e;
      always @(negedge clk) begin
         chk($sformatf("ready_L%0d", g + 1), 32'(b.ready), 32'(!stall && !rst));
         if (rst_d) begin
            chk($sformatf("rst_ins_L%0d", g + 1), b.instruction, 32'h0);
            chk($sformatf("rst_vld_L%0d", g + 1), 32'(b.inst_valid), 32'h0);
            chk($sformatf("rst_err_L%0d", g + 1), 32'(b.addr_err), 32'h0);
         end
         if (stall_d && !rst_d) begin
            chk($sformatf("frz_ins_L%0d", g + 1), b.instruction, prev_ins);
            chk($sformatf("frz_vld_L%0d", g + 1), 32'(b.inst_valid), 32'(prev_v));
         end
         if (!rst && !stall && b.inst_valid) begin
            if (sb[g].size() == 0) begin
               chk($sformatf("spurious_L%0d", g + 1), 32'(b.inst_valid), 32'h0);
            end else begin
               e = sb[g].pop_front();
               chk($sformatf("data_L%0d", g + 1), b.instruction, e.d);
               chk($sformatf("err_L%0d", g + 1), 32'(b.addr_err), 32'(e.e));
               chk($sformatf("lat_L%0d", g + 1), 32'(cyc - e.k - (stall_n - e.s)), 32'(g + 1));
            end
         end
         rst_d    <= rst;
         stall_d  <= stall;
         prev_ins <= b.instruction;
         prev_v   <= b.inst_valid;
      end
   end
   task automatic step(input logic r, input logic [31:0] a, input logic s, input logic f,
                       input logic w, input logic [31:0] pa, input logic [31:0] pd, input logic rs);
      ent_t e;
      logic ok;
      req = r; addr = a; stall = s; flush = f; prog_we = w; prog_addr = pa; prog_data = pd; rst = rs;
      if (w && !rs && pa[31:8] == 0) model[pa[7:2]] = pd;
      if (r && !s && !f && !rs) begin
         ok  = (a[31:8] == 0) && (a[1:0] == 2'b00);
         e.d = ok ? model[a[7:2]] : 32'h0;
         e.e = !ok;
         e.k = cyc;
         e.s = stall_n;
         for (int g = 0; g < 3; g++) sb[g].push_back(e);
      end
      @(posedge clk);
      #1;
      if (f || rs) for (int g = 0; g < 3; g++) sb[g].delete();
   endtask
   task automatic fetch(input logic [31:0] a);
      step(1, a, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   logic [31:0] prog [4] = '{32'hE3A00014, 32'hE3A01A01, 32'hE3A02103, 32'hE0923002};
   initial begin
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'(i * 4), prog[i], 0);
      idle(3);
      for (int i = 0; i < 4; i++) fetch(32'(i * 4));
      idle(5);
      fetch(0);
      fetch(4);
      for (int i = 0; i < 3; i++) step(1, 8, 1, 0, 0, 0, 0, 0);
      fetch(8);
      idle(5);
      fetch(0);
      fetch(4);
      step(1, 8, 0, 1, 0, 0, 0, 0);
      idle(1);
      fetch(12);
      idle(5);
      fetch(256);
      fetch(6);
      idle(1);
      step(0, 0, 0, 0, 1, 256, 32'hDEADBEEF, 0);
      fetch(0);
      idle(4);
      step(1, 20, 0, 0, 1, 20, 32'hEAFFFFFF, 0);
      idle(4);
      fetch(0);
      fetch(4);
      step(1, 8, 0, 0, 0, 0, 0, 1);
      fetch(4);
      fetch(20);
      idle(6);
      for (int g = 0; g < 3; g++) chk($sformatf("drain_L%0d", g + 1), 32'(sb[g].size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
